// File: rtl/addsub_arbiter.sv
// Two-port arbiter sharing one external BCD/binary add-sub unit; one operation per 3 cycles.
// Latency: grant edge k -> ACK in cycle k+1 -> DONE (with registered result) in cycle k+2.
// Backpressure: requests are level-held until ACK; requests seen while busy wait for the next IDLE.
module addsub_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [15:0] A0,
   input  logic [15:0] A1,
   input  logic [15:0] B0,
   input  logic [15:0] B1,
   input  logic        CI0,
   input  logic        CI1,
   input  logic        ADD0,
   input  logic        ADD1,
   input  logic        BCD0,
   input  logic        BCD1,
   input  logic        W16_0,
   input  logic        W16_1,
   output logic        ACK0,
   output logic        ACK1,
   output logic        DONE0,
   output logic        DONE1,
   output logic        BUSY,
   output logic [15:0] U_A,
   output logic [15:0] U_B,
   output logic        U_CI,
   output logic        U_ADD,
   output logic        U_BCD,
   output logic        U_W16,
   input  logic [15:0] U_S,
   input  logic        U_CO,
   input  logic        U_VO,
   output logic [15:0] RES,
   output logic        RES_C,
   output logic        RES_V,
   output logic        RES_N,
   output logic        RES_Z
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;     // port granted most recently
   logic        gnt_q, gnt_d;       // port owning the operation in flight
   logic [15:0] u_a_q, u_a_d, u_b_q, u_b_d;
   logic        u_ci_q, u_ci_d, u_add_q, u_add_d, u_bcd_q, u_bcd_d, u_w16_q, u_w16_d;
   logic [15:0] res_q, res_d;
   logic        res_c_q, res_c_d, res_v_q, res_v_d, res_n_q, res_n_d, res_z_q, res_z_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d, done0_q, done0_d, done1_q, done1_d;
   logic        win1;
   logic [15:0] res_w;

   // Port 1 wins when alone, or on a contest in round-robin mode if port 0 was granted last.
   assign win1 = REQ1 & (~REQ0 | ((RR_EN != 0) & ~last_q));

   // In 8-bit mode the high byte of operand A passes through untouched.
   assign res_w = u_w16_q ? U_S : {u_a_q[15:8], U_S[7:0]};

   // Next-state and next-output computation for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      u_a_d   = u_a_q;
      u_b_d   = u_b_q;
      u_ci_d  = u_ci_q;
      u_add_d = u_add_q;
      u_bcd_d = u_bcd_q;
      u_w16_d = u_w16_q;
      res_d   = res_q;
      res_c_d = res_c_q;
      res_v_d = res_v_q;
      res_n_d = res_n_q;
      res_z_d = res_z_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (REQ0 | REQ1) begin
               last_d  = win1;
               gnt_d   = win1;
               u_a_d   = win1 ? A1    : A0;
               u_b_d   = win1 ? B1    : B0;
               u_ci_d  = win1 ? CI1   : CI0;
               u_add_d = win1 ? ADD1  : ADD0;
               u_bcd_d = win1 ? BCD1  : BCD0;
               u_w16_d = win1 ? W16_1 : W16_0;
               ack0_d  = ~win1;
               ack1_d  = win1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = res_w;
            res_c_d = U_CO;
            res_v_d = U_VO;
            res_n_d = u_w16_q ? res_w[15] : res_w[7];
            res_z_d = u_w16_q ? (res_w == 16'h0000) : (res_w[7:0] == 8'h00);
            done0_d = ~gnt_q;
            done1_d = gnt_q;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All state and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         u_a_q   <= '0;
         u_b_q   <= '0;
         u_ci_q  <= 1'b0;
         u_add_q <= 1'b0;
         u_bcd_q <= 1'b0;
         u_w16_q <= 1'b0;
         res_q   <= '0;
         res_c_q <= 1'b0;
         res_v_q <= 1'b0;
         res_n_q <= 1'b0;
         res_z_q <= 1'b1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         u_a_q   <= u_a_d;
         u_b_q   <= u_b_d;
         u_ci_q  <= u_ci_d;
         u_add_q <= u_add_d;
         u_bcd_q <= u_bcd_d;
         u_w16_q <= u_w16_d;
         res_q   <= res_d;
         res_c_q <= res_c_d;
         res_v_q <= res_v_d;
         res_n_q <= res_n_d;
         res_z_q <= res_z_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

   assign BUSY  = (state_q != ST_IDLE);
   assign ACK0  = ack0_q;
   assign ACK1  = ack1_q;
   assign DONE0 = done0_q;
   assign DONE1 = done1_q;
   assign U_A   = u_a_q;
   assign U_B   = u_b_q;
   assign U_CI  = u_ci_q;
   assign U_ADD = u_add_q;
   assign U_BCD = u_bcd_q;
   assign U_W16 = u_w16_q;
   assign RES   = res_q;
   assign RES_C = res_c_q;
   assign RES_V = res_v_q;
   assign RES_N = res_n_q;
   assign RES_Z = res_z_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: round-robin and fixed-priority instances share stimulus.
// Each instance drives its own behavioural model of the shared add/sub unit.
// Directed vectors with hand-computed results; outputs sampled 1 time unit after the rising edge.
module tb_addsub_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req0, req1;
   logic [15:0] a0, a1, b0, b1;
   logic        ci0, ci1, add0, add1, bcd0, bcd1, w0, w1;

   logic        r_ack0, r_ack1, r_done0, r_done1, r_busy, r_uci, r_uadd, r_ubcd, r_uw16;
   logic [15:0] r_ua, r_ub, r_res;
   logic        r_c, r_v, r_n, r_z;
   logic [17:0] r_u;
   logic        f_ack0, f_ack1, f_done0, f_done1, f_busy, f_uci, f_uadd, f_ubcd, f_uw16;
   logic [15:0] f_ua, f_ub, f_res;
   logic        f_c, f_v, f_n, f_z;
   logic [17:0] f_u;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural shared unit: returns {vo, co, s}; in 8-bit mode the high byte is junk (0xEE).
   function automatic logic [17:0] unit_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic add, input logic bcd,
                                          input logic w16);
      logic [15:0] s, bx;
      logic [16:0] t;
      logic        co, vo;
      int          c, d, da, db, nd;
      s  = '0;
      co = 1'b0;
      vo = 1'b0;
      nd = w16 ? 4 : 2;
      if (!bcd) begin
         bx = add ? b : ~b;
         if (w16) begin
            t  = {1'b0, a} + {1'b0, bx} + {16'b0, ci};
            s  = t[15:0];
            co = t[16];
            vo = (a[15] == bx[15]) && (s[15] != a[15]);
         end else begin
            t     = {9'b0, a[7:0]} + {9'b0, bx[7:0]} + {16'b0, ci};
            s[7:0] = t[7:0];
            co    = t[8];
            vo    = (a[7] == bx[7]) && (s[7] != a[7]);
         end
      end else begin
         c = ci ? 1 : 0;
         for (int i = 0; i < nd; i++) begin
            da = int'(a[i*4 +: 4]);
            db = int'(b[i*4 +: 4]);
            if (add) begin
               d = da + db + c;
               c = (d > 9) ? 1 : 0;
               if (c == 1) d = d - 10;
            end else begin
               d = da - db - (1 - c);
               c = (d >= 0) ? 1 : 0;
               if (c == 0) d = d + 10;
            end
            s[i*4 +: 4] = d[3:0];
         end
         co = (c == 1);
      end
      if (!w16) s[15:8] = 8'hEE;
      return {vo, co, s};
   endfunction

   assign r_u = unit_f(r_ua, r_ub, r_uci, r_uadd, r_ubcd, r_uw16);
   assign f_u = unit_f(f_ua, f_ub, f_uci, f_uadd, f_ubcd, f_uw16);

   addsub_arbiter #(.RR_EN(1)) dut_rr (
      .CLK(clk), .RST_N(rst_n), .REQ0(req0), .REQ1(req1),
      .A0(a0), .A1(a1), .B0(b0), .B1(b1), .CI0(ci0), .CI1(ci1),
      .ADD0(add0), .ADD1(add1), .BCD0(bcd0), .BCD1(bcd1), .W16_0(w0), .W16_1(w1),
      .ACK0(r_ack0), .ACK1(r_ack1), .DONE0(r_done0), .DONE1(r_done1), .BUSY(r_busy),
      .U_A(r_ua), .U_B(r_ub), .U_CI(r_uci), .U_ADD(r_uadd), .U_BCD(r_ubcd), .U_W16(r_uw16),
      .U_S(r_u[15:0]), .U_CO(r_u[16]), .U_VO(r_u[17]),
      .RES(r_res), .RES_C(r_c), .RES_V(r_v), .RES_N(r_n), .RES_Z(r_z)
   );

   addsub_arbiter #(.RR_EN(0)) dut_fp (
      .CLK(clk), .RST_N(rst_n), .REQ0(req0), .REQ1(req1),
      .A0(a0), .A1(a1), .B0(b0), .B1(b1), .CI0(ci0), .CI1(ci1),
      .ADD0(add0), .ADD1(add1), .BCD0(bcd0), .BCD1(bcd1), .W16_0(w0), .W16_1(w1),
      .ACK0(f_ack0), .ACK1(f_ack1), .DONE0(f_done0), .DONE1(f_done1), .BUSY(f_busy),
      .U_A(f_ua), .U_B(f_ub), .U_CI(f_uci), .U_ADD(f_uadd), .U_BCD(f_ubcd), .U_W16(f_uw16),
      .U_S(f_u[15:0]), .U_CO(f_u[16]), .U_VO(f_u[17]),
      .RES(f_res), .RES_C(f_c), .RES_V(f_v), .RES_N(f_n), .RES_Z(f_z)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic drive(input int p, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic add, input logic bcd, input logic w16);
      if (p == 0) begin
         a0 = a; b0 = b; ci0 = ci; add0 = add; bcd0 = bcd; w0 = w16;
      end else begin
         a1 = a; b1 = b; ci1 = ci; add1 = add; bcd1 = bcd; w1 = w16;
      end
   endtask

   // Lone request on port p from IDLE; checks ACK, DONE, result, flags {C,V,N,Z} and hold.
   task automatic do_op(input string tag, input int p, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic add, input logic bcd, input logic w16,
                        input logic [15:0] er, input logic [3:0] ef);
      @(negedge clk);
      drive(p, a, b, ci, add, bcd, w16);
      if (p == 0) req0 = 1'b1; else req1 = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ack"}, {r_ack1, r_ack0}, (p == 0) ? 2'b01 : 2'b10);
      chk({tag, "_busy"}, r_busy, 1);
      req0 = 1'b0;
      req1 = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_done"}, {r_done1, r_done0}, (p == 0) ? 2'b01 : 2'b10);
      chk({tag, "_res"}, r_res, er);
      chk({tag, "_flags"}, {r_c, r_v, r_n, r_z}, ef);
      chk({tag, "_fp_res"}, f_res, er);
      @(posedge clk); #1;
      chk({tag, "_idle"}, {r_busy, r_done1, r_done0, r_ack1, r_ack0}, 0);
      chk({tag, "_hold"}, r_res, er);
   endtask

   initial begin
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {r_ack0, r_ack1, r_done0, r_done1, r_busy}, 0);
      chk("rst_res", r_res, 16'h0000);
      chk("rst_flags", {r_c, r_v, r_n, r_z}, 4'b0001);
      chk("rst_ua", {r_ua, r_ub}, 0);
      @(negedge clk) rst_n = 1'b1;

      // Binary 16-bit add, port 0 (first grant right after reset).
      do_op("add16", 0, 16'h1234, 16'h0FFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2233, 4'b0000);
      // BCD 8-bit add, port 1: 58+46 = 104, high byte of A passes through.
      do_op("bcd8", 1, 16'hAB58, 16'h0046, 1'b0, 1'b1, 1'b1, 1'b0, 16'hAB04, 4'b1000);
      // Subtract to zero, 16-bit binary.
      do_op("subz", 0, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b1001);
      // Signed overflow: 0x7FFF + 1.
      do_op("ovf", 0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 4'b0110);
      // BCD 16-bit subtract with borrow: 0100 - 0200 = 9900, borrow (C=0).
      do_op("bsub", 1, 16'h0100, 16'h0200, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9900, 4'b0010);

      // A request raised while busy and dropped before IDLE is never granted.
      @(negedge clk);
      drive(0, 16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1);
      req0 = 1'b1;
      @(posedge clk); #1;
      chk("drop_ack0", r_ack0, 1);
      req0 = 1'b0;
      req1 = 1'b1;
      @(posedge clk); #1;
      chk("drop_ack1_resp", r_ack1, 0);
      chk("drop_res", r_res, 16'h0008);
      @(negedge clk) req1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("drop_no_grant", {r_busy, r_ack1, r_done1}, 0);
      end

      // Reset during EXEC aborts the operation; held REQ0 is re-granted after release.
      @(negedge clk);
      drive(0, 16'h0102, 16'h0304, 1'b0, 1'b1, 1'b0, 1'b1);
      req0 = 1'b1;
      @(posedge clk); #1;
      chk("abort_ack0", r_ack0, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_now", {r_busy, r_ack0, r_done0, r_res}, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", {r_done0, r_busy}, 0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("regrant_ack0", r_ack0, 1);
      req0 = 1'b0;
      @(posedge clk); #1;
      chk("regrant_done", {r_done0, r_res}, {1'b1, 16'h0406});

      // Contest after reset: round-robin 0,1,0,1 vs fixed priority always port 0.
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1, 16'h0200, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b1);
      req0 = 1'b1;
      req1 = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      for (int g = 0; g < 4; g++) begin
         @(posedge clk); #1;
         chk("rr_ack", {r_ack1, r_ack0}, (g % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_ua", r_ua, (g % 2 == 0) ? 16'h0010 : 16'h0200);
         chk("fp_ack", {f_ack1, f_ack0}, 2'b01);
         if (g == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         @(posedge clk); #1;
         chk("rr_done", {r_done1, r_done0}, (g % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_res", r_res, (g % 2 == 0) ? 16'h0011 : 16'h0300);
         chk("fp_done", {f_done1, f_done0, f_res}, {2'b01, 16'h0011});
         @(posedge clk); #1;
         chk("gap_quiet", {r_ack1, r_ack0, r_done1, r_done0, f_ack1, f_ack0, f_done1, f_done0}, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
